// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Brief    : Hold/flush controller for a 5-stage pipeline. It handles
//             load-use hazards, EX-resolved redirects with wrong-path squash,
//             and multi-cycle MEM accesses with a sticky wait watchdog.
//  Option   : define PIPE_CTRL_PERF_EN to add the StallCount/FlushCount
//             performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
   parameter int ADDR_WIDTH   = 64,
   parameter int FLUSH_CYCLES = 2,
   parameter int MEM_TIMEOUT  = 255
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  ExJumpFlag,
   input  logic [ADDR_WIDTH-1:0] ExJumpAddr,
   input  logic [6:0]            ExOpCode,
   input  logic [4:0]            ExRdAddr,
   input  logic                  ExRdWriteEnable,
   input  logic [4:0]            IdRs1Addr,
   input  logic [4:0]            IdRs2Addr,
   input  logic                  IdRs1Read,
   input  logic                  IdRs2Read,
   input  logic                  MemReq,
   input  logic                  MemReady,
   output logic                  PcHold,
   output logic                  IfIdHold,
   output logic                  IdExHold,
   output logic                  ExMemHold,
   output logic                  IfIdFlush,
   output logic                  IdExFlush,
   output logic                  PcJumpFlag,
   output logic [ADDR_WIDTH-1:0] PcJumpAddr,
   output logic                  MemTimeout,
`ifdef PIPE_CTRL_PERF_EN
   output logic [31:0]           StallCount,
   output logic [31:0]           FlushCount,
`endif
   output logic [1:0]            CtrlState
);

   localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam int WCW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [FCW-1:0] FLUSH_INIT = FCW'(FLUSH_CYCLES - 1);
   localparam logic [WCW-1:0] WAIT_MAX   = WCW'(MEM_TIMEOUT);
   localparam logic [6:0]     OP_LOAD    = 7'b0000011;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FLUSH    = 2'd2,
      ST_UNUSED   = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [FCW-1:0]   flush_cnt_q, flush_cnt_d;
   logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
   logic             mem_timeout_q, mem_timeout_d;

   logic             mem_stall;
   logic             load_use;
   logic             pc_hold, ifid_hold, idex_hold, exmem_hold;
   logic             ifid_flush, idex_flush, jump_flag;
   logic [ADDR_WIDTH-1:0] jump_addr;

   // Hazard terms seen by every state
   always_comb begin
      mem_stall = MemReq & ~MemReady;
      load_use  = (ExOpCode == OP_LOAD) & ExRdWriteEnable & (ExRdAddr != 5'd0) &
                  ((IdRs1Read & (IdRs1Addr == ExRdAddr)) |
                   (IdRs2Read & (IdRs2Addr == ExRdAddr)));
   end

   // Next-state and control decode; a MEM_WAIT exit reuses the RUN rules so
   // a pending redirect or load-use is acted on without a lost cycle
   always_comb begin
      state_d       = state_q;
      flush_cnt_d   = flush_cnt_q;
      wait_cnt_d    = '0;
      mem_timeout_d = mem_timeout_q;
      pc_hold       = 1'b0;
      ifid_hold     = 1'b0;
      idex_hold     = 1'b0;
      exmem_hold    = 1'b0;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;
      jump_flag     = 1'b0;
      jump_addr     = '0;

      if (mem_stall) begin
         wait_cnt_d = (wait_cnt_q >= WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
      end

      case (state_q)
         ST_RUN, ST_MEM_WAIT: begin
            if (mem_stall) begin
               pc_hold    = 1'b1;
               ifid_hold  = 1'b1;
               idex_hold  = 1'b1;
               exmem_hold = 1'b1;
               state_d    = ST_MEM_WAIT;
            end else if (ExJumpFlag) begin
               jump_flag  = 1'b1;
               jump_addr  = ExJumpAddr;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_d     = ST_FLUSH;
                  flush_cnt_d = FLUSH_INIT;
               end else begin
                  state_d = ST_RUN;
               end
            end else if (load_use) begin
               pc_hold    = 1'b1;
               ifid_hold  = 1'b1;
               idex_flush = 1'b1;
               state_d    = ST_RUN;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (mem_stall) begin
               pc_hold    = 1'b1;
               ifid_hold  = 1'b1;
               idex_hold  = 1'b1;
               exmem_hold = 1'b1;
            end else begin
               ifid_flush  = 1'b1;
               flush_cnt_d = flush_cnt_q - 1'b1;
               if (flush_cnt_q <= FCW'(1)) begin
                  flush_cnt_d = '0;
                  state_d     = ST_RUN;
               end
            end
         end
         default: begin
            state_d     = ST_RUN;
            flush_cnt_d = '0;
         end
      endcase

      if (mem_stall && (wait_cnt_d == WAIT_MAX)) begin
         mem_timeout_d = 1'b1;
      end
   end

   // Controller state, counters and sticky watchdog flag
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q       <= ST_RUN;
         flush_cnt_q   <= '0;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         flush_cnt_q   <= flush_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   // Controls are forced low while reset is asserted, independent of inputs
   always_comb begin
      PcHold     = Rst & pc_hold;
      IfIdHold   = Rst & ifid_hold;
      IdExHold   = Rst & idex_hold;
      ExMemHold  = Rst & exmem_hold;
      IfIdFlush  = Rst & ifid_flush;
      IdExFlush  = Rst & idex_flush;
      PcJumpFlag = Rst & jump_flag;
      PcJumpAddr = Rst ? jump_addr : '0;
      MemTimeout = mem_timeout_q;
      CtrlState  = state_q;
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] redirect_cnt_q, redirect_cnt_d;

   // Saturating counts of stalled cycles and accepted redirects
   always_comb begin
      stall_cnt_d    = stall_cnt_q;
      redirect_cnt_d = redirect_cnt_q;
      if (PcHold && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (PcJumpFlag && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
         redirect_cnt_d = redirect_cnt_q + 32'd1;
      end
   end

   // Performance counter registers
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         stall_cnt_q    <= '0;
         redirect_cnt_q <= '0;
      end else begin
         stall_cnt_q    <= stall_cnt_d;
         redirect_cnt_q <= redirect_cnt_d;
      end
   end

   assign StallCount = stall_cnt_q;
   assign FlushCount = redirect_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Brief    : Directed self-checking bench for pipe_hazard_ctrl
//             (MEM_TIMEOUT=4, FLUSH_CYCLES=2). Expected outputs are queued
//             per step and compared when the step's outputs are sampled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

   localparam logic [6:0] NONE = 7'b0000000;
   localparam logic [6:0] LU   = 7'b1100010;
   localparam logic [6:0] JMP  = 7'b0000111;
   localparam logic [6:0] FL   = 7'b0000100;
   localparam logic [6:0] HOLD = 7'b1111000;
   localparam logic [6:0] LOAD = 7'b0000011;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        ExJumpFlag = 1'b0;
   logic [63:0] ExJumpAddr = '0;
   logic [6:0]  ExOpCode = '0;
   logic [4:0]  ExRdAddr = '0;
   logic        ExRdWriteEnable = 1'b0;
   logic [4:0]  IdRs1Addr = '0;
   logic [4:0]  IdRs2Addr = '0;
   logic        IdRs1Read = 1'b0;
   logic        IdRs2Read = 1'b0;
   logic        MemReq = 1'b0;
   logic        MemReady = 1'b0;
   logic        PcHold, IfIdHold, IdExHold, ExMemHold;
   logic        IfIdFlush, IdExFlush, PcJumpFlag, MemTimeout;
   logic [63:0] PcJumpAddr;
   logic [1:0]  CtrlState;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] StallCount, FlushCount;
`endif

   typedef struct packed {
      logic [6:0]  ctrl;
      logic [63:0] addr;
      logic [1:0]  st;
      logic        to;
   } exp_t;

   exp_t  sb[$];
   string tag_q[$];
   int    n_assert = 0;
   int    n_fail   = 0;

   pipe_hazard_ctrl #(
      .ADDR_WIDTH   (64),
      .FLUSH_CYCLES (2),
      .MEM_TIMEOUT  (4)
   ) dut (
      .Clk             (Clk),
      .Rst             (Rst),
      .ExJumpFlag      (ExJumpFlag),
      .ExJumpAddr      (ExJumpAddr),
      .ExOpCode        (ExOpCode),
      .ExRdAddr        (ExRdAddr),
      .ExRdWriteEnable (ExRdWriteEnable),
      .IdRs1Addr       (IdRs1Addr),
      .IdRs2Addr       (IdRs2Addr),
      .IdRs1Read       (IdRs1Read),
      .IdRs2Read       (IdRs2Read),
      .MemReq          (MemReq),
      .MemReady        (MemReady),
      .PcHold          (PcHold),
      .IfIdHold        (IfIdHold),
      .IdExHold        (IdExHold),
      .ExMemHold       (ExMemHold),
      .IfIdFlush       (IfIdFlush),
      .IdExFlush       (IdExFlush),
      .PcJumpFlag      (PcJumpFlag),
      .PcJumpAddr      (PcJumpAddr),
      .MemTimeout      (MemTimeout),
`ifdef PIPE_CTRL_PERF_EN
      .StallCount      (StallCount),
      .FlushCount      (FlushCount),
`endif
      .CtrlState       (CtrlState)
   );

   always #5 Clk = ~Clk;

   task automatic clr_in();
      ExJumpFlag = 1'b0; ExJumpAddr = '0; ExOpCode = '0; ExRdAddr = '0;
      ExRdWriteEnable = 1'b0; IdRs1Addr = '0; IdRs2Addr = '0;
      IdRs1Read = 1'b0; IdRs2Read = 1'b0; MemReq = 1'b0; MemReady = 1'b0;
   endtask

   task automatic set_load(input logic [6:0] op, input logic [4:0] rd, input logic we,
                           input logic [4:0] rs1, input logic r1,
                           input logic [4:0] rs2, input logic r2);
      ExOpCode = op; ExRdAddr = rd; ExRdWriteEnable = we;
      IdRs1Addr = rs1; IdRs1Read = r1; IdRs2Addr = rs2; IdRs2Read = r2;
   endtask

   task automatic push_exp(input string tag, input logic [6:0] c, input logic [63:0] a,
                           input logic [1:0] s, input logic t);
      exp_t e;
      e.ctrl = c; e.addr = a; e.st = s; e.to = t;
      sb.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic check_out();
      exp_t       e;
      string      tag;
      logic [6:0] obs;
      if (sb.size() == 0) begin
         n_assert++; n_fail++;
         $error("FAIL scoreboard_empty observed=0 entries expected=1 entry");
         return;
      end
      e   = sb.pop_front();
      tag = tag_q.pop_front();
      obs = {PcHold, IfIdHold, IdExHold, ExMemHold, IfIdFlush, IdExFlush, PcJumpFlag};
      n_assert++;
      assert (obs === e.ctrl) else begin
         n_fail++;
         $error("FAIL %s ctrl observed=%b expected=%b", tag, obs, e.ctrl);
      end
      n_assert++;
      assert (PcJumpAddr === e.addr) else begin
         n_fail++;
         $error("FAIL %s addr observed=%h expected=%h", tag, PcJumpAddr, e.addr);
      end
      n_assert++;
      assert (CtrlState === e.st) else begin
         n_fail++;
         $error("FAIL %s state observed=%0d expected=%0d", tag, CtrlState, e.st);
      end
      n_assert++;
      assert (MemTimeout === e.to) else begin
         n_fail++;
         $error("FAIL %s timeout observed=%b expected=%b", tag, MemTimeout, e.to);
      end
   endtask

   // Inputs already applied at posedge+1; sample at negedge, then advance
   task automatic step(input string tag, input logic [6:0] c, input logic [63:0] a,
                       input logic [1:0] s, input logic t);
      push_exp(tag, c, a, s, t);
      @(negedge Clk);
      check_out();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      // Asynchronous reset; a live jump request must not leak through
      #1 Rst = 1'b0;
      ExJumpFlag = 1'b1; ExJumpAddr = 64'hDEAD_BEEF;
      #1 push_exp("reset", NONE, 64'h0, 2'd0, 1'b0);
      check_out();
      clr_in();
      #10 Rst = 1'b1;
      @(posedge Clk); #1;

      step("idle", NONE, 64'h0, 2'd0, 1'b0);

      // Load-use hazards
      set_load(LOAD, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
      step("lu_rs2", LU, 64'h0, 2'd0, 1'b0);
      clr_in();
      step("lu_after", NONE, 64'h0, 2'd0, 1'b0);
      set_load(LOAD, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
      step("lu_rd0", NONE, 64'h0, 2'd0, 1'b0);
      set_load(LOAD, 5'd7, 1'b1, 5'd7, 1'b1, 5'd3, 1'b1);
      step("lu_rs1", LU, 64'h0, 2'd0, 1'b0);
      set_load(LOAD, 5'd7, 1'b1, 5'd7, 1'b0, 5'd7, 1'b0);
      step("lu_noread", NONE, 64'h0, 2'd0, 1'b0);
      set_load(7'b0110011, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1);
      step("lu_alu_op", NONE, 64'h0, 2'd0, 1'b0);
      set_load(LOAD, 5'd7, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1);
      step("lu_no_we", NONE, 64'h0, 2'd0, 1'b0);
      clr_in();

      // Redirect with two-cycle squash
      ExJumpFlag = 1'b1; ExJumpAddr = 64'h8000_0040;
      step("jmp_c0", JMP, 64'h8000_0040, 2'd0, 1'b0);
      clr_in();
      step("jmp_c1", FL, 64'h0, 2'd2, 1'b0);
      step("jmp_c2", NONE, 64'h0, 2'd0, 1'b0);

      // Jump and load-use are ignored inside FLUSH
      ExJumpFlag = 1'b1; ExJumpAddr = 64'h100;
      step("jmp2_c0", JMP, 64'h100, 2'd0, 1'b0);
      ExJumpAddr = 64'h200;
      set_load(LOAD, 5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0);
      step("flush_ignore", FL, 64'h0, 2'd2, 1'b0);
      clr_in();
      step("flush_done", NONE, 64'h0, 2'd0, 1'b0);

      // Multi-cycle MEM access
      MemReq = 1'b1;
      step("mw_c0", HOLD, 64'h0, 2'd0, 1'b0);
      step("mw_c1", HOLD, 64'h0, 2'd1, 1'b0);
      step("mw_c2", HOLD, 64'h0, 2'd1, 1'b0);
      MemReady = 1'b1;
      step("mw_ready", NONE, 64'h0, 2'd1, 1'b0);
      clr_in();
      step("mw_idle", NONE, 64'h0, 2'd0, 1'b0);

      // Stall masks jump and load-use; jump fires on the release cycle
      MemReq = 1'b1; ExJumpFlag = 1'b1; ExJumpAddr = 64'h1234;
      set_load(LOAD, 5'd4, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0);
      step("sim_c0", HOLD, 64'h0, 2'd0, 1'b0);
      step("sim_c1", HOLD, 64'h0, 2'd1, 1'b0);
      MemReady = 1'b1;
      step("sim_rel", JMP, 64'h1234, 2'd1, 1'b0);
      clr_in();
      step("sim_flush", FL, 64'h0, 2'd2, 1'b0);
      step("sim_idle", NONE, 64'h0, 2'd0, 1'b0);

      // Load-use pending at stall release
      MemReq = 1'b1;
      set_load(LOAD, 5'd6, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
      step("mlu_c0", HOLD, 64'h0, 2'd0, 1'b0);
      MemReady = 1'b1;
      step("mlu_rel", LU, 64'h0, 2'd1, 1'b0);
      clr_in();
      step("mlu_idle", NONE, 64'h0, 2'd0, 1'b0);

      // Stall inside FLUSH freezes the squash counter
      ExJumpFlag = 1'b1; ExJumpAddr = 64'h40;
      step("fs_jmp", JMP, 64'h40, 2'd0, 1'b0);
      clr_in(); MemReq = 1'b1;
      step("fs_st0", HOLD, 64'h0, 2'd2, 1'b0);
      step("fs_st1", HOLD, 64'h0, 2'd2, 1'b0);
      MemReady = 1'b1;
      step("fs_rel", FL, 64'h0, 2'd2, 1'b0);
      clr_in();
      step("fs_idle", NONE, 64'h0, 2'd0, 1'b0);

      // Watchdog: MEM_TIMEOUT=4
      MemReq = 1'b1;
      step("to_c0", HOLD, 64'h0, 2'd0, 1'b0);
      step("to_w1", HOLD, 64'h0, 2'd1, 1'b0);
      step("to_w2", HOLD, 64'h0, 2'd1, 1'b0);
      step("to_w3", HOLD, 64'h0, 2'd1, 1'b0);
      step("to_w4", HOLD, 64'h0, 2'd1, 1'b1);
      step("to_w5", HOLD, 64'h0, 2'd1, 1'b1);
      MemReady = 1'b1;
      step("to_rel", NONE, 64'h0, 2'd1, 1'b1);
      clr_in();
      step("to_sticky", NONE, 64'h0, 2'd0, 1'b1);

      // Asynchronous reset in the middle of FLUSH
      ExJumpFlag = 1'b1; ExJumpAddr = 64'h8000_0040;
      step("rf_jmp", JMP, 64'h8000_0040, 2'd0, 1'b1);
      clr_in();
      #1 push_exp("rf_in_flush", FL, 64'h0, 2'd2, 1'b1);
      check_out();
      #1 Rst = 1'b0;
      #1 push_exp("rf_reset", NONE, 64'h0, 2'd0, 1'b0);
      check_out();
`ifdef PIPE_CTRL_PERF_EN
      n_assert++;
      assert (StallCount === 32'd0) else begin
         n_fail++;
         $error("FAIL perf_stall observed=%0d expected=0", StallCount);
      end
      n_assert++;
      assert (FlushCount === 32'd0) else begin
         n_fail++;
         $error("FAIL perf_flush observed=%0d expected=0", FlushCount);
      end
`endif
      #3 Rst = 1'b1;
      @(posedge Clk); #1;
      step("post_reset", NONE, 64'h0, 2'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
